// File: rtl/rv_pkg.sv
// Shared RV32I definitions: fetch FSM encoding, reset constants and base opcodes.
package rv_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_DONE = 2'd2;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD     = 7'b000_0011;
    localparam logic [6:0] OP_MISC_MEM = 7'b000_1111;
    localparam logic [6:0] OP_R_IMM    = 7'b001_0011;
    localparam logic [6:0] OP_AUIPC    = 7'b001_0111;
    localparam logic [6:0] OP_STORE    = 7'b010_0011;
    localparam logic [6:0] OP_R        = 7'b011_0011;
    localparam logic [6:0] OP_LUI      = 7'b011_0111;
    localparam logic [6:0] OP_B        = 7'b110_0011;
    localparam logic [6:0] OP_JALR     = 7'b110_0111;
    localparam logic [6:0] OP_JAL      = 7'b110_1111;
    localparam logic [6:0] OP_SYSTEM   = 7'b111_0011;

endpackage

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: PC, instruction register and a req/ack read port,
// with redirects arriving mid-fetch held until the fetch retires.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for iFetchReq; redirects write PC directly
// REQ     | oMemReq high, oMemAddr held until iMemAck
// DONE    | one-cycle oFetchDone pulse, then back to IDLE
module instr_fetch_unit
    import rv_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iFetchReq,
    input  logic        iPCWrite,
    input  logic [31:0] iPCNext,
    output logic        oMemReq,
    output logic [31:0] oMemAddr,
    input  logic        iMemAck,
    input  logic [31:0] iMemData,
    output logic [31:0] oInstr,
    output logic [31:0] oPC,
    output logic [31:0] oPCPlus4,
    output logic        oFetchDone,
    output logic        oBusy,
    output logic        oMisaligned
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  ir_pc_q, ir_pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic         misaligned_q, misaligned_d;
    logic [31:0]  eff_pc;

    // A redirect in the same IDLE cycle as the fetch request steers that fetch.
    assign eff_pc = iPCWrite ? iPCNext : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        ir_pc_d      = ir_pc_q;
        addr_d       = addr_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        misaligned_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iPCWrite) begin
                    pc_d = iPCNext;
                end
                if (iFetchReq) begin
                    if (eff_pc[1:0] != 2'b00) begin
                        misaligned_d = 1'b1;
                    end else begin
                        addr_d  = eff_pc;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (iMemAck) begin
                    ir_d    = iMemData;
                    ir_pc_d = addr_q;
                    // Priority: redirect this cycle, then buffered redirect, then sequential.
                    if (iPCWrite) begin
                        pc_d = iPCNext;
                    end else if (pend_valid_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = addr_q + 32'd4;
                    end
                    pend_valid_d = 1'b0;
                    state_d      = ST_DONE;
                end else if (iPCWrite) begin
                    pend_pc_d    = iPCNext;
                    pend_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (iPCWrite) begin
                    pc_d = iPCNext;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= NOP_INSTR;
            ir_pc_q      <= RESET_PC;
            addr_q       <= RESET_PC;
            pend_pc_q    <= 32'd0;
            pend_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            addr_q       <= addr_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Request is decoded from state so an async reset drops it immediately.
    assign oMemReq     = (state_q == ST_REQ);
    assign oMemAddr    = addr_q;
    assign oInstr      = ir_q;
    assign oPC         = ir_pc_q;
    assign oPCPlus4    = ir_pc_q + 32'd4;
    assign oFetchDone  = (state_q == ST_DONE);
    assign oBusy       = (state_q == ST_REQ) || (state_q == ST_DONE);
    assign oMisaligned = misaligned_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; expected values are hand-computed constants.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_done;
    logic        busy;
    logic        misaligned;

    int n_pass;
    int n_total;
    int done_cnt;

    instr_fetch_unit dut (
        .iCLK       (clk),
        .iRST_n     (rst_n),
        .iFetchReq  (fetch_req),
        .iPCWrite   (pc_write),
        .iPCNext    (pc_next),
        .oMemReq    (mem_req),
        .oMemAddr   (mem_addr),
        .iMemAck    (mem_ack),
        .iMemData   (mem_data),
        .oInstr     (instr),
        .oPC        (pc),
        .oPCPlus4   (pc_plus4),
        .oFetchDone (fetch_done),
        .oBusy      (busy),
        .oMisaligned(misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        fetch_req = 1'b0;
        pc_write  = 1'b0;
        pc_next   = 32'd0;
        mem_ack   = 1'b0;
        mem_data  = 32'd0;

        #12;
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_memaddr", mem_addr, 32'h0040_0000);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_pcplus4", pc_plus4, 32'h0040_0004);
        chk("rst_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_misal", {31'd0, misaligned}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // Fetch 1: ack in the first REQ cycle
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("f1_memreq", {31'd0, mem_req}, 32'd1);
        chk("f1_addr", mem_addr, 32'h0040_0000);
        chk("f1_busy", {31'd0, busy}, 32'd1);
        chk("f1_done_early", {31'd0, fetch_done}, 32'd0);
        mem_ack  = 1'b1;
        mem_data = 32'h0050_0093;
        tick();
        mem_ack = 1'b0;
        chk("f1_done", {31'd0, fetch_done}, 32'd1);
        chk("f1_instr", instr, 32'h0050_0093);
        chk("f1_pc", pc, 32'h0040_0000);
        chk("f1_pcplus4", pc_plus4, 32'h0040_0004);
        chk("f1_memreq_off", {31'd0, mem_req}, 32'd0);
        tick();
        chk("f1_done_off", {31'd0, fetch_done}, 32'd0);

        // Fetch 2: ack delayed 3 cycles, four REQ cycles in total
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        if (fetch_done) done_cnt++;
        chk("f2_addr0", mem_addr, 32'h0040_0004);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (fetch_done) done_cnt++;
            chk("f2_memreq_hold", {31'd0, mem_req}, 32'd1);
            chk("f2_addr_hold", mem_addr, 32'h0040_0004);
        end
        mem_ack  = 1'b1;
        mem_data = 32'h00A0_0113;
        tick();
        mem_ack = 1'b0;
        if (fetch_done) done_cnt++;
        chk("f2_instr", instr, 32'h00A0_0113);
        chk("f2_pc", pc, 32'h0040_0004);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (fetch_done) done_cnt++;
        end
        chk("f2_done_pulses", done_cnt, 32'd1);

        // Fetch 3: redirect in the 2nd REQ cycle, ack in the 3rd
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("f3_addr", mem_addr, 32'h0040_0008);
        tick();
        pc_write = 1'b1;
        pc_next  = 32'h0040_0100;
        tick();
        pc_write = 1'b0;
        chk("f3_addr_hold", mem_addr, 32'h0040_0008);
        mem_ack  = 1'b1;
        mem_data = 32'h0020_8233;
        tick();
        mem_ack = 1'b0;
        chk("f3_instr", instr, 32'h0020_8233);
        chk("f3_pc", pc, 32'h0040_0008);
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("f3_redirect_addr", mem_addr, 32'h0040_0100);
        mem_ack  = 1'b1;
        mem_data = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        tick();

        // Fetch 4: redirect and fetch request in the same IDLE cycle
        fetch_req = 1'b1;
        pc_write  = 1'b1;
        pc_next   = 32'h0040_0020;
        tick();
        fetch_req = 1'b0;
        pc_write  = 1'b0;
        chk("f4_addr", mem_addr, 32'h0040_0020);
        chk("f4_memreq", {31'd0, mem_req}, 32'd1);
        mem_ack  = 1'b1;
        mem_data = 32'h0000_0517;
        tick();
        mem_ack = 1'b0;
        chk("f4_pc", pc, 32'h0040_0020);
        tick();

        // Misaligned redirect refuses the fetch
        pc_write = 1'b1;
        pc_next  = 32'h0040_0006;
        tick();
        pc_write  = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_memreq", {31'd0, mem_req}, 32'd0);
        chk("mis_instr", instr, 32'h0000_0517);
        tick();
        chk("mis_pulse_off", {31'd0, misaligned}, 32'd0);
        chk("mis_memreq_off", {31'd0, mem_req}, 32'd0);

        // Wrap at top of address space, ack coincident with a redirect
        fetch_req = 1'b1;
        pc_write  = 1'b1;
        pc_next   = 32'hFFFF_FFFC;
        tick();
        fetch_req = 1'b0;
        pc_write  = 1'b0;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        mem_ack  = 1'b1;
        mem_data = 32'h0000_006F;
        tick();
        mem_ack = 1'b0;
        chk("wrap_pcplus4", pc_plus4, 32'h0000_0000);
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("wrap_next_addr", mem_addr, 32'h0000_0000);
        mem_ack  = 1'b1;
        pc_write = 1'b1;
        pc_next  = 32'h0040_0040;
        mem_data = 32'h0000_0013;
        tick();
        mem_ack  = 1'b0;
        pc_write = 1'b0;
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("ack_redirect_addr", mem_addr, 32'h0040_0040);

        // Reset mid-REQ drops the request without a clock edge
        chk("rstreq_pre", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstreq_drop", {31'd0, mem_req}, 32'd0);
        chk("rstreq_instr", instr, 32'h0000_0013);
        #4;
        rst_n = 1'b1;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("rstreq_pc_addr", mem_addr, 32'h0040_0000);
        chk("rstreq_oPC", pc, 32'h0040_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
